// File: rtl/raster_scanner_pkg.sv
// Shared definitions for the raster traversal stage:
// coordinate width, default screen size and FSM states.
package raster_scanner_pkg;

    localparam int COORD_W      = 10;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SCAN
    } state_e;

endpackage

// File: rtl/raster_scanner_if.sv
// Triangle-in / pixel-out bundle of the raster scanner.
// master drives triangles and consumes pixels; slave is the scanner.
interface raster_scanner_if
    import raster_scanner_pkg::*;
();

    logic   tri_valid;
    logic   tri_ready;
    coord_t in_ax, in_ay, in_bx, in_by, in_cx, in_cy;
    coord_t ax, ay, bx, by, cx, cy;
    logic   pix_valid;
    logic   pix_ready;
    coord_t x, y;
    logic   pix_last;
    logic   busy;

    modport master (
        output tri_valid, pix_ready,
        output in_ax, in_ay, in_bx, in_by, in_cx, in_cy,
        input  tri_ready, pix_valid, pix_last, busy,
        input  ax, ay, bx, by, cx, cy, x, y
    );

    modport slave (
        input  tri_valid, pix_ready,
        input  in_ax, in_ay, in_bx, in_by, in_cx, in_cy,
        output tri_ready, pix_valid, pix_last, busy,
        output ax, ay, bx, by, cx, cy, x, y
    );

endinterface

// File: rtl/raster_scanner_min_max3.sv
// Combinational minimum and maximum of three coordinates.
module min_max3
    import raster_scanner_pkg::*;
(
    input  coord_t a_i,
    input  coord_t b_i,
    input  coord_t c_i,
    output coord_t min_o,
    output coord_t max_o
);

    always_comb begin
        min_o = a_i;
        if (b_i < min_o) min_o = b_i;
        if (c_i < min_o) min_o = c_i;
        max_o = a_i;
        if (b_i > max_o) max_o = b_i;
        if (c_i > max_o) max_o = c_i;
    end

endmodule

// File: rtl/raster_scanner.sv
// Triangle bounding-box walker: latches vertices, clamps the box
// to the screen and emits every pixel of it in raster order.
module raster_scanner
    import raster_scanner_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input logic             clk,
    input logic             rst_n,
    raster_scanner_if.slave bus
);

    localparam coord_t XLIM = coord_t'(SCREEN_W - 1);
    localparam coord_t YLIM = coord_t'(SCREEN_H - 1);

    state_e state_q;
    coord_t ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
    coord_t xmin_q, xmax_q, ymax_q;
    coord_t x_q, y_q;
    logic   tri_ready_q, pix_valid_q, pix_last_q, busy_q;

    coord_t xmn, xmx, ymn, ymx;
    coord_t xmax_c, ymax_c;
    logic   empty_c;
    coord_t x_d, y_d;
    logic   last_d;

    min_max3 u_mm_x (
        .a_i  (ax_q),
        .b_i  (bx_q),
        .c_i  (cx_q),
        .min_o(xmn),
        .max_o(xmx)
    );

    min_max3 u_mm_y (
        .a_i  (ay_q),
        .b_i  (by_q),
        .c_i  (cy_q),
        .min_o(ymn),
        .max_o(ymx)
    );

    always_comb begin
        xmax_c  = (xmx > XLIM) ? XLIM : xmx;
        ymax_c  = (ymx > YLIM) ? YLIM : ymx;
        empty_c = (xmn > XLIM) || (ymn > YLIM);
    end

    // Raster step and look-ahead of the last-pixel flag.
    always_comb begin
        x_d = x_q + coord_t'(1);
        y_d = y_q;
        if (x_q == xmax_q) begin
            x_d = xmin_q;
            y_d = y_q + coord_t'(1);
        end
        last_d = (x_d == xmax_q) && (y_d == ymax_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ax_q        <= '0;
            ay_q        <= '0;
            bx_q        <= '0;
            by_q        <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymax_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            tri_ready_q <= 1'b1;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.tri_valid) begin
                        ax_q        <= bus.in_ax;
                        ay_q        <= bus.in_ay;
                        bx_q        <= bus.in_bx;
                        by_q        <= bus.in_by;
                        cx_q        <= bus.in_cx;
                        cy_q        <= bus.in_cy;
                        tri_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    if (empty_c) begin
                        tri_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        xmin_q      <= xmn;
                        xmax_q      <= xmax_c;
                        ymax_q      <= ymax_c;
                        x_q         <= xmn;
                        y_q         <= ymn;
                        pix_valid_q <= 1'b1;
                        pix_last_q  <= (xmn == xmax_c) && (ymn == ymax_c);
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    if (bus.pix_ready) begin
                        if (pix_last_q) begin
                            pix_valid_q <= 1'b0;
                            pix_last_q  <= 1'b0;
                            tri_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            x_q        <= x_d;
                            y_q        <= y_d;
                            pix_last_q <= last_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tri_ready = tri_ready_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_last  = pix_last_q;
    assign bus.busy      = busy_q;
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.ax        = ax_q;
    assign bus.ay        = ay_q;
    assign bus.bx        = bx_q;
    assign bus.by        = by_q;
    assign bus.cx        = cx_q;
    assign bus.cy        = cy_q;

endmodule

// File: tb/tb_raster_scanner.sv
// Bench for raster_scanner: reference box walk built from
// nested loops over the clamped bounding box.
module tb_raster_scanner;
    import raster_scanner_pkg::*;

    localparam int W = 640;
    localparam int H = 480;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    raster_scanner_if bus();

    raster_scanner #(
        .SCREEN_W(W),
        .SCREEN_H(H)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Called on a falling edge while the scanner is idle.
    task automatic run_tri(input int ax, input int ay, input int bx,
                           input int by, input int cx, input int cy,
                           input bit rnd, input string nm);
        int q[$];
        int xmn, xmx, ymn, ymx, cyc;
        bit pr, pv;
        xmn = min3(ax, bx, cx);
        xmx = max3(ax, bx, cx);
        ymn = min3(ay, by, cy);
        ymx = max3(ay, by, cy);
        if (xmx > W - 1) xmx = W - 1;
        if (ymx > H - 1) ymx = H - 1;
        if (xmn <= W - 1 && ymn <= H - 1)
            for (int yy = ymn; yy <= ymx; yy++)
                for (int xx = xmn; xx <= xmx; xx++)
                    q.push_back(yy * 1024 + xx);

        n_cmp++;
        if (bus.tri_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept: tri_ready=%b want 1", nm, bus.tri_ready);
        end
        bus.in_ax = coord_t'(ax);
        bus.in_ay = coord_t'(ay);
        bus.in_bx = coord_t'(bx);
        bus.in_by = coord_t'(by);
        bus.in_cx = coord_t'(cx);
        bus.in_cy = coord_t'(cy);
        bus.tri_valid = 1'b1;
        bus.pix_ready = 1'b0;
        @(negedge clk);
        bus.tri_valid = 1'b0;

        n_cmp++;
        if ({bus.tri_ready, bus.busy, bus.pix_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL %s setup: rdy/busy/pv=%b%b%b want 010", nm,
                     bus.tri_ready, bus.busy, bus.pix_valid);
        end
        n_cmp++;
        if ({bus.ax, bus.ay, bus.bx, bus.by, bus.cx, bus.cy} !==
            {coord_t'(ax), coord_t'(ay), coord_t'(bx),
             coord_t'(by), coord_t'(cx), coord_t'(cy)}) begin
            n_fail++;
            $display("FAIL %s vertices: got %0d,%0d %0d,%0d %0d,%0d", nm,
                     bus.ax, bus.ay, bus.bx, bus.by, bus.cx, bus.cy);
        end
        @(negedge clk);

        if (q.size() == 0) begin
            n_cmp++;
            if ({bus.tri_ready, bus.busy, bus.pix_valid} !== 3'b100) begin
                n_fail++;
                $display("FAIL %s empty: rdy/busy/pv=%b%b%b want 100", nm,
                         bus.tri_ready, bus.busy, bus.pix_valid);
            end
            return;
        end

        n_cmp++;
        if (bus.pix_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s latency: pix_valid=%b want 1", nm, bus.pix_valid);
        end

        cyc = 0;
        while (q.size() > 0 && cyc < 4000) begin
            n_cmp++;
            if (bus.pix_valid !== 1'b1 ||
                bus.x !== coord_t'(q[0] % 1024) ||
                bus.y !== coord_t'(q[0] / 1024) ||
                bus.pix_last !== 1'(q.size() == 1)) begin
                n_fail++;
                $display("FAIL %s pixel: pv=%b (%0d,%0d) last=%b want (%0d,%0d) last=%0d",
                         nm, bus.pix_valid, bus.x, bus.y, bus.pix_last,
                         q[0] % 1024, q[0] / 1024, q.size() == 1);
            end
            pv = (bus.pix_valid === 1'b1);
            pr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.pix_ready = pr;
            @(negedge clk);
            cyc++;
            if (pr && pv) void'(q.pop_front());
        end
        bus.pix_ready = 1'b0;

        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s timeout: %0d pixels left want 0", nm, q.size());
        end
        n_cmp++;
        if ({bus.tri_ready, bus.busy, bus.pix_valid, bus.pix_last} !== 4'b1000) begin
            n_fail++;
            $display("FAIL %s done: rdy/busy/pv/last=%b%b%b%b want 1000", nm,
                     bus.tri_ready, bus.busy, bus.pix_valid, bus.pix_last);
        end
    endtask

    task automatic check_reset_vals(input string nm);
        n_cmp++;
        if ({bus.tri_ready, bus.pix_valid, bus.pix_last, bus.busy} !== 4'b1000 ||
            {bus.x, bus.y} !== 20'd0 ||
            {bus.ax, bus.ay, bus.bx, bus.by, bus.cx, bus.cy} !== 60'd0) begin
            n_fail++;
            $display("FAIL %s: rdy/pv/last/busy=%b%b%b%b x=%0d y=%0d ax=%0d want 1000 zeros",
                     nm, bus.tri_ready, bus.pix_valid, bus.pix_last, bus.busy,
                     bus.x, bus.y, bus.ax);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_tri(10, 20, 13, 20, 10, 22, 1'b0, "basic");
    endtask

    task automatic test_stall();
        run_tri(10, 20, 13, 20, 10, 22, 1'b1, "stall");
    endtask

    task automatic test_clamp();
        run_tri(630, 470, 700, 470, 630, 600, 1'b1, "clamp");
    endtask

    task automatic test_offscreen();
        run_tri(700, 10, 800, 10, 750, 20, 1'b0, "offscreen");
    endtask

    task automatic test_back_to_back();
        run_tri(5, 5, 5, 5, 5, 5, 1'b0, "point");
        run_tri(100, 200, 102, 200, 100, 201, 1'b1, "b2b");
    endtask

    task automatic test_reset_midwalk();
        bus.in_ax = 10'd10;
        bus.in_ay = 10'd20;
        bus.in_bx = 10'd13;
        bus.in_by = 10'd20;
        bus.in_cx = 10'd10;
        bus.in_cy = 10'd22;
        bus.tri_valid = 1'b1;
        @(negedge clk);
        bus.tri_valid = 1'b0;
        bus.pix_ready = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({bus.pix_valid, bus.x, bus.y} !== {1'b1, 10'd13, 10'd20}) begin
            n_fail++;
            $display("FAIL midwalk pixel4: pv=%b (%0d,%0d) want 1 (13,20)",
                     bus.pix_valid, bus.x, bus.y);
        end
        rst_n = 1'b0;
        #1;
        check_reset_vals("midwalk_reset");
        bus.pix_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.tri_ready, bus.pix_valid, bus.pix_last} !== 3'b100) begin
            n_fail++;
            $display("FAIL midwalk after release: rdy/pv/last=%b%b%b want 100",
                     bus.tri_ready, bus.pix_valid, bus.pix_last);
        end
        run_tri(50, 60, 52, 61, 51, 60, 1'b1, "after_reset");
    endtask

    task automatic test_random();
        int bx0, by0;
        for (int i = 0; i < 8; i++) begin
            bx0 = $urandom_range(0, 700);
            by0 = $urandom_range(0, 500);
            run_tri(bx0 + $urandom_range(0, 4), by0 + $urandom_range(0, 4),
                    bx0 + $urandom_range(0, 4), by0 + $urandom_range(0, 4),
                    bx0 + $urandom_range(0, 4), by0 + $urandom_range(0, 4),
                    1'b1, "random");
        end
    endtask

    initial begin
        bus.tri_valid = 1'b0;
        bus.pix_ready = 1'b0;
        bus.in_ax = '0;
        bus.in_ay = '0;
        bus.in_bx = '0;
        bus.in_by = '0;
        bus.in_cx = '0;
        bus.in_cy = '0;
        test_reset();
        test_basic();
        test_stall();
        test_clamp();
        test_offscreen();
        test_back_to_back();
        test_reset_midwalk();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/raster_scanner.md
# raster_scanner

Triangle traversal stage that sits directly upstream of the `rasterizer` edge-function block. It accepts one triangle per handshake and computes its screen-clamped bounding box. It then walks every pixel of that box in raster order, presenting one `(x, y)` per cycle together with stable, registered vertex coordinates to drive the rasterizer's inputs. Back-pressure from the downstream pixel consumer stalls the walk without losing or repeating pixels.

## Interface
- `SCREEN_W`, default 640: horizontal resolution; x range 0..SCREEN_W-1.
- `SCREEN_H`, default 480: vertical resolution; y range 0..SCREEN_H-1.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tri_valid`  in  1  triangle vertices on `in_ax..in_cy` are valid.
- `tri_ready`  out  1  scanner can accept a triangle; high only in IDLE.
- `in_ax, in_ay, in_bx, in_by, in_cx, in_cy`  in  10 each  unsigned vertex coordinates.
- `ax, ay, bx, by, cx, cy`  out  10 each  latched vertices, stable for the whole walk.
- `pix_valid`  out  1  `x`, `y` hold a pixel to consume.
- `pix_ready`  in  1  downstream accepts the current pixel.
- `x`, `y`  out  10 each  current pixel coordinate.
- `pix_last`  out  1  current pixel is the final one of this triangle; qualified by `pix_valid`.
- `busy`  out  1  a triangle is in SETUP or SCAN.

## Operation
- States: IDLE, SETUP, SCAN.
- **IDLE**
  - `tri_ready`=1.
  - On `tri_valid`, latch all six vertices and go to SETUP.
- **SETUP** (one cycle)
  - xmin = min(ax,bx,cx); xmax = min(max(ax,bx,cx), SCREEN_W-1).
  - ymin = min(ay,by,cy); ymax = min(max(ay,by,cy), SCREEN_H-1).
  - If xmin > SCREEN_W-1 or ymin > SCREEN_H-1, the box is empty: return to IDLE and emit no pixel.
  - Otherwise load x=xmin, y=ymin and go to SCAN.
- **SCAN**
  - `pix_valid`=1. A pixel transfers when `pix_valid && pix_ready`.
  - On transfer with x<xmax: x++.
  - On transfer with x==xmax and y<ymax: x=xmin, y++.
  - On transfer with x==xmax and y==ymax (`pix_last`=1): go to IDLE.
  - Without transfer, x, y and `pix_last` hold.
- Degenerate triangles (zero area, collinear, or single point) are still walked over their box. Rejection belongs to the rasterizer's `visible`.
- Single-pixel box (xmin==xmax, ymin==ymax): exactly one pixel, with `pix_last`=1.
- All comparisons are unsigned, 10-bit. Clamp constants are computed from the parameters at elaboration.

## Timing
- Reset values:
  - state=IDLE.
  - `tri_ready`=1; `pix_valid`, `pix_last`, `busy`=0.
  - x, y and all vertex outputs = 0.
- Triangle accepted at edge N. SETUP occupies cycle N+1. The first `pix_valid` appears in cycle N+2.
- Throughput is one pixel per cycle while `pix_ready`=1. Pixel count = (xmax-xmin+1)·(ymax-ymin+1).
- The vertex outputs change only on triangle acceptance. They are stable from SETUP through the last transfer.
- `tri_ready` returns to 1 in the cycle after the last transfer, or the cycle after SETUP for an empty box.
- No overlap between triangles: back-to-back triangles leave a 2-cycle gap (IDLE accept, then SETUP).
- `rst_n` asserted mid-walk: all outputs go to reset values immediately. The partial triangle is discarded, with no further pixels and no `pix_last`.
- `pix_ready` may toggle arbitrarily. `pix_valid` never drops in SCAN until the last pixel is transferred.

## Structure
- The shared raster package holds:
  - coordinate width constant `COORD_W`=10;
  - default screen dimensions;
  - state enum {IDLE, SETUP, SCAN}.
- One natural sub-module, `min_max3`: three 10-bit inputs, combinational min and max outputs. It is instantiated twice, once for x and once for y.
- The FSM, bounding-box registers and the x/y counter live in `raster_scanner`. No outputs are driven combinationally from inputs except through the state register.

## Test plan
- Triangle (10,20),(13,20),(10,22), `pix_ready`=1:
  - 12 pixels, (10,20)…(13,20),(10,21)…(13,22);
  - `pix_last` only on (13,22);
  - first `pix_valid` 2 cycles after accept.
- Same triangle with `pix_ready` toggled pseudo-randomly: identical 12-pixel sequence, no duplicates or drops, x/y stable while stalled.
- Triangle (630,470),(700,470),(630,600): box clamped to x 630..639, y 470..479, giving 100 pixels; last is (639,479).
- Triangle fully offscreen, (700,10),(800,10),(750,20): no `pix_valid`, `tri_ready` high again 2 cycles after accept.
- Point triangle (5,5)×3: one pixel (5,5) with `pix_last`=1. Back-to-back second triangle accepted on the first IDLE cycle.
- `rst_n` pulsed low during pixel 4 of the first test: outputs go to 0 and `tri_ready` goes to 1 immediately. A new triangle after release is walked correctly from its own xmin/ymin.
